// File: rtl/adc_read.sv
// adc_read: capture side of the converter path.
// Registers parallel ADC samples, converts offset binary to two's complement,
// averages 2^N samples and presents results through a 2-entry stream buffer.
module adc_read #(
    parameter int unsigned INT_ADC_DATA_WIDTH = 14,
    parameter int unsigned INT_DECIM_MAX_LOG2 = 4,
    parameter logic        BIT_OFFSET_BINARY  = 1'b1
) (
    input  logic                                         in_clk,
    input  logic                                         in_rst,
    input  logic [INT_ADC_DATA_WIDTH-1:0]                in_data,
    input  logic                                         in_valid,
    input  logic                                         in_enable,
    input  logic [$clog2(INT_DECIM_MAX_LOG2+1)-1:0]      in_decim_log2,
    input  logic                                         in_ready,
    output logic [INT_ADC_DATA_WIDTH-1:0]                out_data,
    output logic                                         out_clip,
    output logic                                         out_valid,
    output logic [15:0]                                  out_drop_count
);

    localparam int unsigned DW = INT_ADC_DATA_WIDTH;
    localparam int unsigned NW = $clog2(INT_DECIM_MAX_LOG2 + 1);
    localparam int unsigned AW = INT_ADC_DATA_WIDTH + INT_DECIM_MAX_LOG2;
    localparam int unsigned CW = INT_DECIM_MAX_LOG2 + 1;

    // Stage 1 / 2 registers
    logic [DW-1:0]        s1_data;
    logic                 s1_valid;
    logic signed [DW-1:0] s2_data;
    logic                 s2_clip;
    logic                 s2_valid;

    // Stage 3 accumulator state
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic                 blk_clip;
    logic [NW-1:0]        n_lat;
    logic                 res_valid;
    logic [DW-1:0]        res_data;
    logic                 res_clip;

    // Output buffer state
    logic [DW-1:0]        mem_data [2];
    logic                 mem_clip [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;

    // Stage 3 combinational terms
    logic [NW-1:0]        n_req_c;
    logic [NW-1:0]        n_cur_c;
    logic signed [AW-1:0] acc_base_c;
    logic signed [AW-1:0] sample_ext_c;
    logic signed [AW-1:0] sum_c;
    logic signed [AW-1:0] shifted_c;
    logic                 last_c;
    logic                 clip_c;

    // Buffer handshake terms
    logic                 pop_c;
    logic                 push_ok_c;
    logic                 drop_c;

    // Capture raw pins every edge
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_data  <= in_data;
            s1_valid <= in_valid;
        end
    end

    // Format conversion and full-scale detection on the raw code
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            s2_data  <= '0;
            s2_clip  <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (BIT_OFFSET_BINARY) begin
                s2_data <= {~s1_data[DW-1], s1_data[DW-2:0]};
            end else begin
                s2_data <= s1_data;
            end
            s2_clip  <= (&s1_data) || !(|s1_data);
            s2_valid <= s1_valid;
        end
    end

    // Block arithmetic: N is taken live at block start, latched thereafter
    always_comb begin
        n_req_c      = (in_decim_log2 > NW'(INT_DECIM_MAX_LOG2)) ? NW'(INT_DECIM_MAX_LOG2) : in_decim_log2;
        n_cur_c      = (cnt == '0) ? n_req_c : n_lat;
        acc_base_c   = (cnt == '0) ? AW'(0) : acc;
        sample_ext_c = AW'(s2_data);
        sum_c        = acc_base_c + sample_ext_c;
        shifted_c    = sum_c >>> n_cur_c;
        last_c       = (cnt == ((CW'(1) << n_cur_c) - CW'(1)));
        clip_c       = ((cnt == '0) ? 1'b0 : blk_clip) | s2_clip;
    end

    // Accumulate valid samples and emit one result per completed block
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt       <= '0;
            acc       <= '0;
            blk_clip  <= 1'b0;
            n_lat     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_clip  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (!in_enable) begin
                cnt      <= '0;
                acc      <= '0;
                blk_clip <= 1'b0;
            end else if (s2_valid) begin
                acc      <= sum_c;
                blk_clip <= clip_c;
                if (cnt == '0) begin
                    n_lat <= n_req_c;
                end
                if (last_c) begin
                    cnt       <= '0;
                    res_valid <= 1'b1;
                    res_data  <= shifted_c[DW-1:0];
                    res_clip  <= clip_c;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Buffer accept/drop decision
    always_comb begin
        pop_c     = (count != 2'd0) && in_ready;
        push_ok_c = res_valid && ((count != 2'd2) || pop_c);
        drop_c    = res_valid && !push_ok_c;
    end

    // Two-entry output FIFO with saturating drop counter
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_clip[i] <= 1'b0;
            end
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= 2'd0;
            out_drop_count <= 16'd0;
        end else begin
            if (push_ok_c) begin
                mem_data[wr_ptr] <= res_data;
                mem_clip[wr_ptr] <= res_clip;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_c) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok_c, pop_c})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (drop_c && (out_drop_count != 16'hFFFF)) begin
                out_drop_count <= out_drop_count + 16'd1;
            end
        end
    end

    // Head of buffer drives the stream
    assign out_valid = (count != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_clip  = mem_clip[rd_ptr];

endmodule

// File: tb/tb_adc_read.sv
// tb_adc_read: randomized and directed stimulus against a sample-level
// averaging model; a forked monitor checks every accepted output in order.
module tb_adc_read;

    typedef struct packed {
        logic [13:0] data;
        logic        clip;
    } exp_t;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [13:0] in_data;
    logic        in_valid;
    logic        in_enable;
    logic [2:0]  in_decim_log2;
    logic        in_ready;
    logic [13:0] out_data;
    logic        out_clip;
    logic        out_valid;
    logic [15:0] out_drop_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   blk[$];
    int   blk_n;
    logic blk_clip;
    logic use_model = 1'b1;
    int   ready_mode = 0;

    adc_read dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_enable      (in_enable),
        .in_decim_log2  (in_decim_log2),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_clip       (out_clip),
        .out_valid      (out_valid),
        .out_drop_count (out_drop_count)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] to_raw(input int v);
        return 14'(v + 8192);
    endfunction

    // Reference: collect 2^N two's complement values, floor-average them
    task automatic model_sample(input logic [13:0] raw);
        int   v;
        int   sum;
        int   d;
        int   q;
        exp_t e;
        v = int'(raw) - 8192;
        if (blk.size() == 0) begin
            blk_n    = (in_decim_log2 > 3'd4) ? 4 : int'(in_decim_log2);
            blk_clip = 1'b0;
        end
        blk.push_back(v);
        blk_clip = blk_clip | (raw == 14'h0000) | (raw == 14'h3FFF);
        d = 1 << blk_n;
        if (blk.size() == d) begin
            sum = 0;
            foreach (blk[i]) sum += blk[i];
            q = sum / d;
            if ((sum % d != 0) && (sum < 0)) q = q - 1;
            e.data = 14'(q);
            e.clip = blk_clip;
            exp_q.push_back(e);
            blk.delete();
        end
    endtask

    task automatic step(input logic v, input logic [13:0] d);
        in_valid = v;
        in_data  = d;
        if (v && in_enable && use_model) model_sample(d);
        case (ready_mode)
            0:       in_ready = 1'b1;
            1:       in_ready = !in_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
            default: in_ready = 1'b0;
        endcase
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 14'h0);
    endtask

    function automatic logic [13:0] rand_raw();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 14'h0000;
        if (r == 1) return 14'h3FFF;
        return 14'($urandom);
    endfunction

    task automatic rand_step();
        if ($urandom_range(0, 9) < 7) step(1'b1, rand_raw());
        else step(1'b0, 14'h0);
    endtask

    task automatic finish_block();
        int guard;
        guard = 0;
        while (blk.size() != 0 && guard < 64) begin
            step(1'b1, rand_raw());
            guard++;
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            step(1'b0, 14'h0);
            i++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    task automatic lat_check(input logic [13:0] raw, input string name);
        step(1'b1, raw);
        check({name, "_e0"}, 32'(out_valid), 32'd0);
        step(1'b0, 14'h0);
        check({name, "_e1"}, 32'(out_valid), 32'd0);
        step(1'b0, 14'h0);
        check({name, "_e2"}, 32'(out_valid), 32'd0);
        step(1'b0, 14'h0);
        check({name, "_e3"}, 32'(out_valid), 32'd1);
    endtask

    // Monitor: pop expected on every accepted beat, check hold under stall
    task automatic monitor();
        exp_t        e;
        logic        hold;
        logic [13:0] hd;
        logic        hc;
        hold = 1'b0;
        hd   = '0;
        hc   = 1'b0;
        forever begin
            @(negedge in_clk);
            if (in_rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(hd));
                    check("hold_clip", 32'(out_clip), 32'(hc));
                end
                if (out_valid && in_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got data 0x%0h, expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_clip", 32'(out_clip), 32'(e.clip));
                    end
                end
                hold = out_valid && !in_ready;
                hd   = out_data;
                hc   = out_clip;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   list[6];
        in_rst        = 1'b1;
        in_data       = '0;
        in_valid      = 1'b0;
        in_enable     = 1'b1;
        in_decim_log2 = 3'd0;
        in_ready      = 1'b1;
        fork
            monitor();
        join_none

        repeat (2) @(posedge in_clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_clip", 32'(out_clip), 32'd0);
        check("rst_drop", 32'(out_drop_count), 32'd0);
        in_rst = 1'b0;
        idle(2);

        // Format conversion and latency, N=0
        lat_check(14'h2000, "lat_fmt");
        step(1'b1, 14'h3FFF);
        step(1'b1, 14'h0000);
        drain("fmt");

        // Averaging, N=2
        in_decim_log2 = 3'd2;
        foreach (list[i]) list[i] = 0;
        step(1'b1, to_raw(10)); step(1'b1, to_raw(11));
        step(1'b1, to_raw(12)); step(1'b1, to_raw(13));
        step(1'b1, to_raw(-1)); step(1'b1, to_raw(-2));
        step(1'b1, to_raw(-2)); step(1'b1, to_raw(-2));
        drain("avg");

        // Gapped valid, N=1
        in_decim_log2 = 3'd1;
        step(1'b1, to_raw(100));
        idle(3);
        step(1'b1, to_raw(102));
        drain("gap");

        // Enable flush mid-block, N=2
        in_decim_log2 = 3'd2;
        step(1'b1, to_raw(100)); step(1'b1, to_raw(100));
        idle(3);
        in_enable = 1'b0;
        blk.delete();
        step(1'b0, 14'h0);
        in_enable = 1'b1;
        idle(2);
        repeat (4) step(1'b1, to_raw(8));
        drain("enable");

        // Decimation change mid-block applies at next block
        step(1'b1, to_raw(40)); step(1'b1, to_raw(41));
        idle(3);
        in_decim_log2 = 3'd0;
        step(1'b1, to_raw(42)); step(1'b1, to_raw(-45));
        step(1'b1, to_raw(7)); step(1'b1, to_raw(-7));
        drain("decim_change");

        // Randomized: N=0 free-flowing, then N=1..4 and clamped codes with stalls
        ready_mode = 0;
        repeat (40) rand_step();
        list = '{1, 2, 3, 4, 5, 7};
        foreach (list[k]) begin
            finish_block();
            idle(3);
            in_decim_log2 = 3'(list[k]);
            ready_mode    = 1;
            repeat (60) rand_step();
        end
        finish_block();
        drain("random");
        ready_mode = 0;
        check("random_drop", 32'(out_drop_count), 32'd0);

        // Backpressure with drops, N=0
        idle(3);
        in_decim_log2 = 3'd0;
        use_model     = 1'b0;
        ready_mode    = 2;
        for (int i = 1; i <= 5; i++) step(1'b1, to_raw(i));
        idle(5);
        check("bp_drop", 32'(out_drop_count), 32'd3);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'd1);
        e.data = 14'd1; e.clip = 1'b0; exp_q.push_back(e);
        e.data = 14'd2; e.clip = 1'b0; exp_q.push_back(e);
        ready_mode = 0;
        drain("bp");
        check("bp_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with full buffer and partial block
        ready_mode = 2;
        step(1'b1, to_raw(5)); step(1'b1, to_raw(6));
        idle(3);
        in_decim_log2 = 3'd2;
        step(1'b1, to_raw(7));
        idle(3);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_drop", 32'(out_drop_count), 32'd3);
        #2;
        in_rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_clip", 32'(out_clip), 32'd0);
        check("arst_drop", 32'(out_drop_count), 32'd0);
        exp_q.delete();
        blk.delete();
        @(negedge in_clk);
        in_rst        = 1'b0;
        in_decim_log2 = 3'd0;
        ready_mode    = 0;
        use_model     = 1'b1;
        @(posedge in_clk);
        #1;
        lat_check(to_raw(-1234), "lat_post_rst");
        step(1'b1, to_raw(555));
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
